pc_fetch_pipe: RTL
==================

Name: pc_fetch_pipe

Overview:
- Fetch-side counterpart of the next-PC selector. Owns the PC register and produces the values the selector consumes: PC_plus_4 for the IF stage and the EX-stage PC+4 (PC_EX). Consumes the selected PC_next_clk.
- Carries PC+4 down the IF/ID and ID/EX registers with valid bits.
- Applies hazard stalls, flushes the wrong path on EX redirects, and handles a halt/resume state machine.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the optional event counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- PC_next_clk  in  32  next PC from the selector.
- redirect  in  1  branch|Jmp|Jr resolved taken in EX.
- stall  in  1  hazard hold of IF and ID, e.g. load-use.
- halt  in  1  syscall/halt decoded in EX.
- go  in  1  resume pulse.
- PC_IF  out  32  current fetch address.
- PC_plus_4  out  32  PC_IF + 4, combinational.
- PC_ID  out  32  ID-stage PC+4.
- PC_EX  out  32  EX-stage PC+4.
- valid_ID  out  1  ID slot holds a real instruction.
- valid_EX  out  1  EX slot holds a real instruction.
- halted  out  1  high in the HALTED state.
- redirect_cnt  out  CNT_W  taken redirects (optional feature).
- stall_cnt  out  CNT_W  stall cycles (optional feature).

Behaviour:
- Reset (asynchronous, any time, including mid-halt):
  - PC_IF = RESET_PC; PC_ID = PC_EX = 0.
  - valid_ID = valid_EX = 0; state RUN; halted = 0; counters = 0.
- PC_plus_4 = PC_IF + 32'd4, modulo 2^32. 32'hFFFF_FFFC yields 0.
- Qualification: redirect and halt are acted on only when valid_EX = 1; otherwise they are ignored.
- RUN, per clock, in priority order:
  1. halt (qualified):
     - Go to HALTED.
     - PC_IF, PC_ID and PC_EX hold.
     - valid_ID <= 0, valid_EX <= 0.
  2. redirect (qualified):
     - PC_IF <= PC_next_clk.
     - PC_ID <= PC_plus_4; PC_EX <= PC_ID.
     - valid_ID <= 0, valid_EX <= 0, killing both wrong-path slots.
     - Redirect overrides a simultaneous stall.
  3. stall:
     - PC_IF and PC_ID hold; valid_ID holds.
     - PC_EX <= PC_ID; valid_EX <= 0 (bubble).
  4. normal:
     - PC_IF <= PC_next_clk.
     - PC_ID <= PC_plus_4; valid_ID <= 1.
     - PC_EX <= PC_ID; valid_EX <= valid_ID.
- Redirect latency: the redirect target appears on PC_IF one cycle after the redirect is sampled. The first valid instruction reaches EX 3 cycles after the redirect.
- Stall latency: with stall held N cycles, PC_IF is unchanged for N cycles and exactly N bubbles enter EX.
- HALTED:
  - halted = 1; all pipeline registers hold; valid bits stay 0.
  - redirect and stall are ignored.
  - go: return to RUN on the next edge. Fetch resumes at the held PC_IF with valid_ID = 0; normal flow starts from the following edge.
  - go seen in RUN: ignored.
- The block never inspects PC_next_clk content; alignment is the selector's responsibility.

Optional Feature:
- Macro: PC_FETCH_PIPE_COUNT_EN.
- Defined:
  - redirect_cnt increments on each qualified redirect.
  - stall_cnt increments on each RUN cycle with stall = 1 and no qualified redirect or halt.
  - Both counters wrap at 2^CNT_W, hold while HALTED, and are cleared by rst.
- Undefined: both ports are tied to 0 and no counter flops are synthesised.

Decomposition:
- Shared package (mips_pkg):
  - RESET_PC default.
  - Word width constant, 32.
  - Instruction-size constant, 4.
  - State encoding typedef: RUN = 1'b0, HALTED = 1'b1.
- One natural sub-module: pc_stage_reg, a PC+4/valid pipeline register with hold and kill inputs, instantiated twice (IF/ID and ID/EX).
- The PC register and FSM stay in the top module.

Test Plan:
- Reset then 3 normal cycles (PC_next_clk = PC_plus_4):
  - PC_IF steps 0, 4, 8, 0xC.
  - PC_EX = 4 with valid_EX = 1 in cycle 3.
- Redirect with valid_EX = 1 and PC_next_clk = 0x0040_0100:
  - Next cycle PC_IF = 0x0040_0100, valid_ID = valid_EX = 0.
  - redirect_cnt = 1 when the macro is defined.
- Redirect with valid_EX = 0:
  - Ignored; normal advance; counter unchanged.
- stall for 2 cycles at PC_IF = 0x20:
  - PC_IF stays 0x20 for both cycles; two bubbles (valid_EX = 0) enter EX.
  - Simultaneous qualified redirect instead loads the target.
- halt qualified at PC_IF = 0x30:
  - halted = 1, PC_IF frozen at 0x30 for 10 cycles despite redirect toggling.
  - go: RUN, and fetch continues from 0x30.
- PC_IF = 0xFFFF_FFFC: PC_plus_4 = 0; rst asserted mid-HALTED immediately restores PC_IF = RESET_PC and halted = 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch-side constants and the halt/resume state encoding.
package mips_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [WORD_W-1:0] INSN_BYTES = 32'd4;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

endpackage

// File: rtl/pc_fetch_pipe_if.sv
// Handshake bundle between the next-PC selector (master) and pc_fetch_pipe (slave).
interface pc_fetch_pipe_if #(
  parameter int unsigned CNT_W = 32
) ();
  import mips_pkg::*;

  logic [WORD_W-1:0] PC_next_clk;
  logic              redirect;
  logic              stall;
  logic              halt;
  logic              go;
  logic [WORD_W-1:0] PC_IF;
  logic [WORD_W-1:0] PC_plus_4;
  logic [WORD_W-1:0] PC_ID;
  logic [WORD_W-1:0] PC_EX;
  logic              valid_ID;
  logic              valid_EX;
  logic              halted;
  logic [CNT_W-1:0]  redirect_cnt;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output PC_next_clk, redirect, stall, halt, go,
    input  PC_IF, PC_plus_4, PC_ID, PC_EX, valid_ID, valid_EX, halted,
    input  redirect_cnt, stall_cnt
  );

  modport slave (
    input  PC_next_clk, redirect, stall, halt, go,
    output PC_IF, PC_plus_4, PC_ID, PC_EX, valid_ID, valid_EX, halted,
    output redirect_cnt, stall_cnt
  );

endinterface

// File: rtl/pc_stage_reg.sv
// PC+4/valid pipeline register. hold freezes the slot; kill clears valid and wins over hold.
module pc_stage_reg
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              kill,
  input  logic [WORD_W-1:0] pc_in,
  input  logic              valid_in,
  output logic [WORD_W-1:0] pc,
  output logic              valid
);

  logic [WORD_W-1:0] pc_q;
  logic              valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      if (!hold) pc_q <= pc_in;
      if (kill) begin
        valid_q <= 1'b0;
      end else if (!hold) begin
        valid_q <= valid_in;
      end
    end
  end

  assign pc    = pc_q;
  assign valid = valid_q;

endmodule

// File: rtl/pc_fetch_pipe.sv
// PC register, IF/ID and ID/EX PC+4 carriers and halt/resume FSM.
// Optional event counters are built when PC_FETCH_PIPE_COUNT_EN is defined.
module pc_fetch_pipe
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned       CNT_W    = 32
) (
  input logic           clk,
  input logic           rst,
  pc_fetch_pipe_if.slave bus
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] pc_if_q, pc_if_d;
  logic [WORD_W-1:0] pc_plus_4;
  logic [WORD_W-1:0] id_pc, ex_pc;
  logic              id_valid, ex_valid;
  logic              id_hold, id_kill, ex_hold, ex_kill;

  assign pc_plus_4 = pc_if_q + INSN_BYTES;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_if_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_if_q <= pc_if_d;
    end
  end

  // redirect and halt only count when EX holds a real instruction.
  always_comb begin
    state_d = state_q;
    pc_if_d = pc_if_q;
    id_hold = 1'b0;
    id_kill = 1'b0;
    ex_hold = 1'b0;
    ex_kill = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.halt && ex_valid) begin
          state_d = HALTED;
          id_hold = 1'b1;
          id_kill = 1'b1;
          ex_hold = 1'b1;
          ex_kill = 1'b1;
        end else if (bus.redirect && ex_valid) begin
          pc_if_d = bus.PC_next_clk;
          id_kill = 1'b1;
          ex_kill = 1'b1;
        end else if (bus.stall) begin
          id_hold = 1'b1;
          ex_kill = 1'b1;
        end else begin
          pc_if_d = bus.PC_next_clk;
        end
      end
      HALTED: begin
        id_hold = 1'b1;
        ex_hold = 1'b1;
        if (bus.go) state_d = RUN;
      end
    endcase
  end

  pc_stage_reg u_if_id (
    .clk      (clk),
    .rst      (rst),
    .hold     (id_hold),
    .kill     (id_kill),
    .pc_in    (pc_plus_4),
    .valid_in (1'b1),
    .pc       (id_pc),
    .valid    (id_valid)
  );

  pc_stage_reg u_id_ex (
    .clk      (clk),
    .rst      (rst),
    .hold     (ex_hold),
    .kill     (ex_kill),
    .pc_in    (id_pc),
    .valid_in (id_valid),
    .pc       (ex_pc),
    .valid    (ex_valid)
  );

  assign bus.PC_IF     = pc_if_q;
  assign bus.PC_plus_4 = pc_plus_4;
  assign bus.PC_ID     = id_pc;
  assign bus.PC_EX     = ex_pc;
  assign bus.valid_ID  = id_valid;
  assign bus.valid_EX  = ex_valid;
  assign bus.halted    = (state_q == HALTED);

`ifdef PC_FETCH_PIPE_COUNT_EN
  logic             redir_take, stall_take;
  logic [CNT_W-1:0] redirect_cnt_q, stall_cnt_q;

  assign redir_take = (state_q == RUN) && ex_valid && bus.redirect && !bus.halt;
  assign stall_take = (state_q == RUN) && bus.stall &&
                      !(ex_valid && (bus.redirect || bus.halt));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      if (redir_take) redirect_cnt_q <= redirect_cnt_q + CNT_W'(1);
      if (stall_take) stall_cnt_q    <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.redirect_cnt = redirect_cnt_q;
  assign bus.stall_cnt    = stall_cnt_q;
`else
  assign bus.redirect_cnt = {CNT_W{1'b0}};
  assign bus.stall_cnt    = {CNT_W{1'b0}};
`endif

endmodule
